// File: rtl/parity_serial_rx_pkg.sv
// Shared definitions for the serial parity link: receiver FSM encoding and
// parity mode constants, also used by the generator and transmitter.
package parity_serial_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/parity_serial_rx_if.sv
// Line-side and word-side signals of the serial frame receiver.
// master: drives the serial line and mode; slave: the receiver itself.
interface parity_serial_rx_if #(
    parameter int unsigned DATA_W = 4
);
    logic              rx;
    logic              mode;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output rx, mode,
        input  data_out, valid, parity_err, frame_err, busy
    );

    modport slave (
        input  rx, mode,
        output data_out, valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/parity_serial_rx_baud_tick_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and wraps, clearable.
// half_tick_o marks the middle of the start bit when counted from its edge;
// full_tick_o marks each following mid-bit point once re-aligned there.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic half_tick_o,
    output logic full_tick_o
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d;

    // next count: clear has priority, otherwise wrap at terminal count
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || (cnt_q == CW'(CLKS_PER_BIT - 1))) begin
            cnt_d = '0;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign half_tick_o = (cnt_q == CW'(CLKS_PER_BIT / 2 - 1));
    assign full_tick_o = (cnt_q == CW'(CLKS_PER_BIT - 1));
endmodule

// File: rtl/parity_serial_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB-first, parity, stop.
// Reports the word with a one-cycle valid plus parity and framing errors.
import parity_serial_rx_pkg::*;

module parity_serial_rx #(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    parity_serial_rx_if.slave  bus
);
    localparam int unsigned BW = $clog2(DATA_W + 1);

    logic [1:0]        sync_q;
    logic              rx_s;
    rx_state_e         state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              baud_clr;
    logic              half_tick;
    logic              full_tick;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (baud_clr),
        .half_tick_o(half_tick),
        .full_tick_o(full_tick)
    );

    // two-flop synchronizer for the asynchronous serial line, idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], bus.rx};
        end
    end

    assign rx_s = sync_q[1];

    // frame FSM next state, sampling and result computation
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        mode_d    = mode_q;
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        valid_d   = 1'b0;
        baud_clr  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // counter held at zero so START counts from the falling edge
                baud_clr = 1'b1;
                if (!rx_s) begin
                    state_d = ST_START;
                    mode_d  = bus.mode;
                end
            end
            ST_START: begin
                if (half_tick) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_DATA;
                        baud_clr = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (full_tick) begin
                    for (int unsigned i = 0; i < DATA_W; i++) begin
                        if (bit_cnt_q == BW'(i)) begin
                            shift_d[i] = rx_s;
                        end
                    end
                    if (bit_cnt_q == BW'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (full_tick) begin
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (full_tick) begin
                    data_d  = shift_q;
                    perr_d  = ((^shift_q) ^ par_q) != mode_q;
                    ferr_d  = ~rx_s;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state, datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            mode_q    <= PARITY_EVEN;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            mode_q    <= mode_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != ST_IDLE);

    // mode_q encodes PARITY_ODD as 1, matching the required total 1-count parity
    logic unused_odd;
    assign unused_odd = PARITY_ODD;
endmodule

// File: tb/tb_parity_serial_rx.sv
// Directed bench for parity_serial_rx with DATA_W=4, CLKS_PER_BIT=4.
module tb_parity_serial_rx;
    localparam int unsigned DW  = 4;
    localparam int unsigned CPB = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // valid-pulse log filled by the monitor
    int       vcount;
    int       vdouble;
    logic     prev_valid;
    logic [3:0] cap_data [0:31];
    logic       cap_perr [0:31];
    logic       cap_ferr [0:31];

    parity_serial_rx_if #(.DATA_W(DW)) bus ();

    parity_serial_rx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // record each valid pulse and flag any pulse longer than one cycle
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            if (vcount < 32) begin
                cap_data[vcount] = bus.data_out;
                cap_perr[vcount] = bus.parity_err;
                cap_ferr[vcount] = bus.frame_err;
            end
            vcount = vcount + 1;
            if (prev_valid === 1'b1) vdouble = vdouble + 1;
        end
        prev_valid = bus.valid;
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic s, input bit flip);
        send_bit(1'b0);
        if (flip) bus.mode = ~bus.mode;
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic wait_vcount(input int target, output bit ok);
        int n;
        n = 0;
        while (vcount < target && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = (vcount >= target);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.rx  = 1'b1;
        bus.mode = 1'b0;
        #12;
        total++; if (bus.data_out !== 4'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.data_out); end
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
        total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", bus.parity_err); end
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", bus.frame_err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // odd mode, mode flipped mid-frame must be ignored
    task automatic test_odd_ok();
        int base;
        bit ok;
        base = vcount;
        bus.mode = 1'b1;
        align();
        send_frame(4'b1110, 1'b0, 1'b1, 1'b1);
        wait_vcount(base + 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL odd_valid timeout count=%0d exp=%0d", vcount, base + 1); end
        total++; if (cap_data[base] !== 4'b1110) begin bad++; $display("FAIL odd_data got=%b exp=1110", cap_data[base]); end
        total++; if (cap_perr[base] !== 1'b0) begin bad++; $display("FAIL odd_perr got=%b exp=0", cap_perr[base]); end
        total++; if (cap_ferr[base] !== 1'b0) begin bad++; $display("FAIL odd_ferr got=%b exp=0", cap_ferr[base]); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_even_parity();
        int base;
        bit ok;
        base = vcount;
        bus.mode = 1'b0;
        align();
        send_frame(4'b1001, 1'b1, 1'b1, 1'b0);
        send_frame(4'b1001, 1'b0, 1'b1, 1'b0);
        wait_vcount(base + 2, ok);
        total++; if (!ok) begin bad++; $display("FAIL even_valid timeout count=%0d exp=%0d", vcount, base + 2); end
        total++; if (cap_data[base] !== 4'b1001) begin bad++; $display("FAIL even_bad_data got=%b exp=1001", cap_data[base]); end
        total++; if (cap_perr[base] !== 1'b1) begin bad++; $display("FAIL even_bad_perr got=%b exp=1", cap_perr[base]); end
        total++; if (cap_ferr[base] !== 1'b0) begin bad++; $display("FAIL even_bad_ferr got=%b exp=0", cap_ferr[base]); end
        total++; if (cap_data[base+1] !== 4'b1001) begin bad++; $display("FAIL even_good_data got=%b exp=1001", cap_data[base+1]); end
        total++; if (cap_perr[base+1] !== 1'b0) begin bad++; $display("FAIL even_good_perr got=%b exp=0", cap_perr[base+1]); end
        total++; if (cap_ferr[base+1] !== 1'b0) begin bad++; $display("FAIL even_good_ferr got=%b exp=0", cap_ferr[base+1]); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame_err();
        int base;
        bit ok;
        base = vcount;
        bus.mode = 1'b1;
        align();
        send_frame(4'b1100, 1'b1, 1'b0, 1'b0);
        bus.rx = 1'b1;
        wait_vcount(base + 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL ferr_valid timeout count=%0d exp=%0d", vcount, base + 1); end
        total++; if (cap_data[base] !== 4'b1100) begin bad++; $display("FAIL ferr_data got=%b exp=1100", cap_data[base]); end
        total++; if (cap_perr[base] !== 1'b0) begin bad++; $display("FAIL ferr_perr got=%b exp=0", cap_perr[base]); end
        total++; if (cap_ferr[base] !== 1'b1) begin bad++; $display("FAIL ferr_ferr got=%b exp=1", cap_ferr[base]); end
        @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ferr_restart_busy got=%b exp=1", bus.busy); end
        repeat (8) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ferr_back_idle got=%b exp=0", bus.busy); end
        total++; if (vcount !== base + 1) begin bad++; $display("FAIL ferr_extra_valid got=%0d exp=%0d", vcount, base + 1); end
    endtask

    task automatic test_glitch();
        int  base;
        bit  seen;
        bit  idle;
        base = vcount;
        seen = 1'b0;
        idle = 1'b0;
        align();
        bus.rx = 1'b0;
        @(posedge clk);
        #1;
        bus.rx = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) seen = 1'b1;
        end
        for (int i = 0; i < 10 && !idle; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) idle = 1'b1;
        end
        repeat (4) @(negedge clk);
        total++; if (!seen) begin bad++; $display("FAIL glitch_busy got=0 exp=1"); end
        total++; if (!idle) begin bad++; $display("FAIL glitch_idle got=%b exp=0", bus.busy); end
        total++; if (vcount !== base) begin bad++; $display("FAIL glitch_valid got=%0d exp=%0d", vcount, base); end
        total++; if (bus.data_out !== 4'b1100) begin bad++; $display("FAIL glitch_data got=%b exp=1100", bus.data_out); end
        total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL glitch_ferr got=%b exp=1", bus.frame_err); end
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        base = vcount;
        bus.mode = 1'b0;
        align();
        send_frame(4'b0101, 1'b0, 1'b1, 1'b0);
        send_frame(4'b1010, 1'b0, 1'b1, 1'b0);
        wait_vcount(base + 2, ok);
        repeat (3) @(negedge clk);
        total++; if (!ok) begin bad++; $display("FAIL b2b_valid timeout count=%0d exp=%0d", vcount, base + 2); end
        total++; if (vcount !== base + 2) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", vcount, base + 2); end
        total++; if (cap_data[base] !== 4'b0101) begin bad++; $display("FAIL b2b_data0 got=%b exp=0101", cap_data[base]); end
        total++; if (cap_data[base+1] !== 4'b1010) begin bad++; $display("FAIL b2b_data1 got=%b exp=1010", cap_data[base+1]); end
        total++; if (cap_perr[base+1] !== 1'b0) begin bad++; $display("FAIL b2b_perr1 got=%b exp=0", cap_perr[base+1]); end
        total++; if (vdouble !== 0) begin bad++; $display("FAIL valid_width long_pulses=%0d exp=0", vdouble); end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        bit ok;
        base = vcount;
        bus.mode = 1'b0;
        align();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.data_out !== 4'h0) begin bad++; $display("FAIL rstmid_data got=%b exp=0000", bus.data_out); end
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", bus.valid); end
        total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL rstmid_perr got=%b exp=0", bus.parity_err); end
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_ferr got=%b exp=0", bus.frame_err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        bus.rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b exp=0", bus.busy); end
        total++; if (vcount !== base) begin bad++; $display("FAIL rstmid_aborted_valid got=%0d exp=%0d", vcount, base); end
        align();
        send_frame(4'b0011, 1'b0, 1'b1, 1'b0);
        wait_vcount(base + 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_valid2 timeout count=%0d exp=%0d", vcount, base + 1); end
        total++; if (cap_data[base] !== 4'b0011) begin bad++; $display("FAIL rstmid_data2 got=%b exp=0011", cap_data[base]); end
        total++; if (cap_perr[base] !== 1'b0) begin bad++; $display("FAIL rstmid_perr2 got=%b exp=0", cap_perr[base]); end
        total++; if (cap_ferr[base] !== 1'b0) begin bad++; $display("FAIL rstmid_ferr2 got=%b exp=0", cap_ferr[base]); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        vcount     = 0;
        vdouble    = 0;
        prev_valid = 1'b0;
        test_reset();
        test_odd_ok();
        test_even_parity();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/parity_serial_rx.md
Name: parity_serial_rx

Overview:
Serial frame receiver sitting downstream of the parity generator on the serial link. It deserializes a frame (start, DATA_W data bits LSB-first, parity, stop) from a single line. It recomputes parity under the selected mode, presents the received word with a one-cycle valid strobe, and flags parity and framing errors. The parity checker logic consumes its output word.

Parameters:
DATA_W, 4, number of data bits per frame (1..16)
CLKS_PER_BIT, 16, clock cycles per serial bit (>=4)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
mode  input  1  parity mode: 0 = even (data+parity has even 1-count), 1 = odd
data_out  output  DATA_W  last received data word
valid  output  1  one-cycle pulse, frame complete
parity_err  output  1  parity mismatch on the frame flagged by valid
frame_err  output  1  stop bit sampled low on the frame flagged by valid
busy  output  1  high from start detection until return to IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; data_out=0; valid=0; parity_err=0; frame_err=0; busy=0; bit and baud counters=0; synchronizer flops=1.
- rx passes through a 2-flop synchronizer (reset to 1). All FSM decisions use the synchronized value rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rx_s=0, go to START, clear baud counter, latch mode into mode_q, set busy=1.
- START: at baud count CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
  - If 1 (glitch): go to IDLE, busy=0, no valid.
  - If 0: reset baud counter, go to DATA.
- DATA: sample rx_s every CLKS_PER_BIT cycles (mid-bit). Shift into shift register LSB-first (first data bit lands in bit 0). After DATA_W samples, go to PARITY.
- PARITY: sample rx_s at mid-bit into par_q, then go to STOP.
- STOP: sample rx_s at mid-bit. In the same cycle:
  - data_out <= shift register
  - parity_err <= (^shift ^ par_q) != mode_q
  - frame_err <= ~rx_s
  - valid <= 1 on the next edge (exactly one cycle)
  - go to IDLE, busy=0
- No wait for the end of the stop bit: a new start edge seen in IDLE is accepted immediately. With a stop bit of 1, the line is high for the rest of that bit, so this is safe.
- data_out, parity_err and frame_err hold their values until the next valid. valid is never high for more than one cycle.
- frame_err frame (stop=0): data_out and parity_err still update. Then IDLE; since rx_s is low, START is re-entered immediately (no break detection).
- mode changes mid-frame are ignored; mode_q is used.
- Reset mid-frame aborts with no valid. After release, receiver resumes in IDLE and waits for a falling edge.
- Latency: valid rises 3 cycles after the mid-stop-bit point on raw rx (2 synchronizer + 1 register).
- Counters: baud counter width clog2(CLKS_PER_BIT); bit counter width clog2(DATA_W+1). Counters wrap to 0 on terminal count only.

Decomposition:
- Shared package/header: state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), PARITY_EVEN=0 / PARITY_ODD=1 constants, reused by the generator and transmitter.
- One natural sub-module: baud_tick_gen (counter with clear input, emits mid-bit tick), reusable by the matching transmitter.
- Synchronizer stays inline.

Test Plan:
- CLKS_PER_BIT=4, DATA_W=4, mode=1: send data 4'b1110 with parity 0, stop 1 -> one valid pulse, data_out=4'b1110, parity_err=0, frame_err=0.
- mode=0: send 4'b1001 with parity 1 -> data_out=4'b1001, parity_err=1. Then send 4'b1001 with parity 0 -> parity_err=0.
- mode=1: send 4'b1100 with parity 1 but stop bit 0 -> data_out=4'b1100, parity_err=0, frame_err=1. Receiver re-enters START.
- Glitch: rx low for 1 cycle only while idle -> busy pulses, returns to IDLE, no valid, outputs unchanged.
- Back-to-back: two frames 4'b0101 and 4'b1010 (even, correct parity) with no idle gap -> two valid pulses, with data_out 4'b0101 then 4'b1010.
- Reset asserted mid-DATA of a frame -> all outputs 0 immediately (asynchronous). Next full frame 4'b0011 after release -> received correctly.
